// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the display/refresh blocks that sit beside the CPU
// register file: refresh FSM states, blank segment code, register-index width.
package cpu_types_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int NUM_DIGITS = 8;
  localparam int NIBBLE_W   = 4;
  localparam int SEG_W      = 7;

  // Active-low segments {g,f,e,d,c,b,a}; all ones turns every segment off.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_UPDATE = 2'd2
  } refresh_state_e;

endpackage

// File: rtl/sevenseg_dec.sv
// Combinational hex-nibble to active-low seven-segment decoder ({g,f,e,d,c,b,a}).
module sevenseg_dec
  import cpu_types_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: every path of a combinational block assigns its outputs (default first), so no latch is inferred.
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_refresh_ctrl.sv
// Periodically reads one register through the shared read port and paints its eight
// nibbles onto HEX0..HEX7, one digit per cycle, from a captured snapshot.
module hex_refresh_ctrl
  import cpu_types_pkg::*;
#(
  parameter logic [15:0]          REFRESH_DIV = 16'd50000,
  parameter logic [REG_IDX_W-1:0] SRC_REG     = 5'd2
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        en,
  input  logic        force_refresh,
  input  logic        clr_ovr,
  output logic        rd_req,
  output logic [4:0]  rd_addr,
  input  logic        rd_gnt,
  input  logic [31:0] rd_data,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic        busy,
  output logic        overrun
);

  refresh_state_e state_q, state_d;

  logic [15:0]                      cnt_q, cnt_d;
  logic [31:0]                      snap_q, snap_d;
  logic [2:0]                       idx_q, idx_d;
  logic                             ovr_q, ovr_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] hex_q, hex_d;

  logic       tick;
  logic       trigger;
  logic       grant_taken;
  logic [3:0] cur_nibble;
  logic [6:0] cur_seg;

  // Tick divider: free-running while enabled, parked at zero otherwise.
  always_comb begin
    cnt_d = 16'd0;
    if (en) begin
      cnt_d = (cnt_q == REFRESH_DIV - 16'd1) ? 16'd0 : cnt_q + 16'd1;
    end
  end

  assign tick        = en && (cnt_q == REFRESH_DIV - 16'd1);
  assign trigger     = tick || force_refresh;
  assign grant_taken = (state_q == ST_REQ) && rd_gnt;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (trigger)           state_d = ST_REQ;
      ST_REQ:    if (rd_gnt)            state_d = ST_UPDATE;
      ST_UPDATE: if (idx_q == 3'd7)     state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Outputs depend on state only, so rd_req drops the cycle after the grant.
  always_comb begin
    rd_req  = (state_q == ST_REQ);
    rd_addr = rd_req ? SRC_REG : '0;
    busy    = (state_q != ST_IDLE);
  end

  // Snapshot, digit index and the write-back of one decoded digit per UPDATE cycle.
  assign cur_nibble = snap_q[{idx_q, 2'b00} +: NIBBLE_W];

  sevenseg_dec u_dec (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_comb begin
    snap_d = snap_q;
    idx_d  = idx_q;
    hex_d  = hex_q;
    if (grant_taken) begin
      snap_d = rd_data;
      idx_d  = 3'd0;
    end
    if (state_q == ST_UPDATE) begin
      hex_d[idx_q] = cur_seg;
      idx_d        = idx_q + 3'd1;
    end
  end

  // A trigger that lands while a refresh is in flight is dropped and flagged; set beats clear.
  always_comb begin
    ovr_d = ovr_q;
    if (trigger && busy) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      snap_q  <= 32'd0;
      idx_q   <= 3'd0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

  // NOTE: the digit registers are a small array but must blank on reset, so they live in a reset flop block rather than a RAM.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      hex_q <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      hex_q <= hex_d;
    end
  end

  assign overrun = ovr_q;

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_hex_refresh_ctrl.sv
// Self-checking bench for hex_refresh_ctrl: transaction-level reference model plus a
// scoreboard that compares each completed display frame against the captured register word.
module tb_hex_refresh_ctrl;

  localparam int DIV = 4;
  localparam int SRC = 2;

  logic        clk = 1'b0;
  logic        nRst;
  logic        en;
  logic        force_refresh;
  logic        clr_ovr;
  logic        rd_gnt;
  logic [31:0] rd_data;
  logic        rd_req;
  logic [4:0]  rd_addr;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic        busy;
  logic        overrun;
  logic [55:0] dut_hex;

  hex_refresh_ctrl #(
    .REFRESH_DIV (16'd4),
    .SRC_REG     (5'd2)
  ) dut (
    .clk           (clk),
    .nRst          (nRst),
    .en            (en),
    .force_refresh (force_refresh),
    .clr_ovr       (clr_ovr),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .rd_data       (rd_data),
    .HEX0          (HEX0),
    .HEX1          (HEX1),
    .HEX2          (HEX2),
    .HEX3          (HEX3),
    .HEX4          (HEX4),
    .HEX5          (HEX5),
    .HEX6          (HEX6),
    .HEX7          (HEX7),
    .busy          (busy),
    .overrun       (overrun)
  );

  assign dut_hex = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [55:0] ALL_BLANK = {8{7'b1111111}};

  // Reference model: tick phase, refresh progress (0 idle, 1 awaiting grant, 2..9 painting
  // digit phase-2), snapshot word, per-digit shown nibble (-1 = blank) and overrun flag.
  int          m_cnt;
  int          m_phase;
  logic [31:0] m_snap;
  int          m_disp [8];
  bit          m_ovr;
  logic [31:0] exp_q [$];
  int          req_cycles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [55:0] frame_of(input logic [31:0] w);
    logic [55:0] v;
    for (int k = 0; k < 8; k++) v[k*7 +: 7] = seg_tab[w[k*4 +: 4]];
    return v;
  endfunction

  function automatic logic [55:0] model_hex();
    logic [55:0] v;
    for (int k = 0; k < 8; k++) v[k*7 +: 7] = (m_disp[k] < 0) ? 7'h7f : seg_tab[m_disp[k]];
    return v;
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_phase = 0;
    m_snap  = 32'd0;
    m_ovr   = 1'b0;
    for (int k = 0; k < 8; k++) m_disp[k] = -1;
    exp_q.delete();
  endtask

  task automatic model_step(input bit e, input bit f, input bit c, input bit g, input logic [31:0] d);
    bit tick, trig, was_busy;
    tick     = e && (m_cnt == DIV - 1);
    trig     = tick || f;
    was_busy = (m_phase != 0);
    if (trig && was_busy) m_ovr = 1'b1;
    else if (c)           m_ovr = 1'b0;
    m_cnt = e ? (m_cnt + 1) % DIV : 0;
    if (m_phase == 0) begin
      if (trig) m_phase = 1;
    end else if (m_phase == 1) begin
      if (g) begin
        m_snap = d;
        exp_q.push_back(d);
        m_phase = 2;
      end
    end else begin
      m_disp[m_phase-2] = int'(m_snap[(m_phase-2)*4 +: 4]);
      m_phase = (m_phase == 9) ? 0 : m_phase + 1;
    end
  endtask

  task automatic check_outputs();
    check("rd_req",  rd_req,  m_phase == 1);
    check("rd_addr", rd_addr, (m_phase == 1) ? SRC : 0);
    check("busy",    busy,    m_phase != 0);
    check("overrun", overrun, m_ovr);
    check("hex",     dut_hex, model_hex());
  endtask

  // One clock: check what the DUT shows now, then present inputs for the next edge.
  task automatic cycle(input bit e, input bit f, input bit c, input bit g, input logic [31:0] d);
    @(negedge clk);
    check_outputs();
    if (rd_req) req_cycles++;
    en            = e;
    force_refresh = f;
    clr_ovr       = c;
    rd_gnt        = g;
    rd_data       = d;
    model_step(e, f, c, g, d);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2;
    nRst          = 1'b0;
    en            = 1'b0;
    force_refresh = 1'b0;
    clr_ovr       = 1'b0;
    rd_gnt        = 1'b0;
    model_reset();
    #1;
    check("rst_hex",     dut_hex, ALL_BLANK);
    check("rst_rd_req",  rd_req,  0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_busy",    busy,    0);
    check("rst_overrun", overrun, 0);
    @(posedge clk);
    #2;
    nRst = 1'b1;
  endtask

  // Scoreboard monitor: whenever a refresh finishes, the whole display must show the expected word.
  initial begin
    bit prev_busy = 1'b0;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (nRst && prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame: refresh finished with no expected word, got %0h", dut_hex);
        end else begin
          w = exp_q.pop_front();
          check("frame", dut_hex, frame_of(w));
        end
      end
      prev_busy = nRst ? busy : 1'b0;
    end
  end

  initial begin
    int first_req;
    nRst          = 1'b0;
    en            = 1'b0;
    force_refresh = 1'b0;
    clr_ovr       = 1'b0;
    rd_gnt        = 1'b0;
    rd_data       = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    nRst = 1'b1;

    // Quiet after reset: nothing enabled, nothing forced.
    req_cycles = 0;
    repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("quiet_req_cycles", req_cycles, 0);

    // Automatic refresh with the grant tied high.
    req_cycles = 0;
    first_req  = -1;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h76543210);
      if (rd_req && first_req < 0) begin
        first_req = i;
        check("auto_rd_addr", rd_addr, SRC);
      end
    end
    check("auto_first_req", first_req, 4);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h76543210);
    check("auto_frame_final", dut_hex, frame_of(32'h76543210));
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

    // Forced refresh with a five-cycle grant stall.
    req_cycles = 0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hFEDCBA98);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'hFEDCBA98);
    repeat (12) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFEDCBA98);
    check("stall_req_cycles", req_cycles, 6);
    check("stall_hex0", HEX0, 7'b0000000);
    check("stall_hex7", HEX7, 7'b0001110);

    // Force during UPDATE is dropped and flagged; clear coinciding with a new overrun keeps it set.
    req_cycles = 0;
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0BADF00D);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0BADF00D);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    check("ovr_set", overrun, 1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0BADF00D);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    check("ovr_set_wins", overrun, 1);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    check("ovr_req_cycles", req_cycles, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("ovr_cleared", overrun, 0);

    // Reset in the middle of painting digit 3.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 20 && m_phase != 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    @(posedge clk);
    #1;
    check("busy_before_rst", busy, 1);
    reset_pulse();
    req_cycles = 0;
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check("post_rst_req_cycles", req_cycles, 0);

    // Tick and force in the same cycle count as one trigger.
    req_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      bit f;
      f = (m_cnt == DIV - 1);
      cycle(1'b1, f, 1'b0, 1'b1, 32'hC0FFEE42);
      if (f) break;
    end
    repeat (12) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hC0FFEE42);
    check("coincide_req_cycles", req_cycles, 1);
    check("coincide_overrun", overrun, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1, $urandom);
    end
    repeat (20) cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_refresh_ctrl.md
HEX_REFRESH_CTRL -- requirements
Module: hex_refresh_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 16'd50000; clk cycles between automatic refresh ticks; legal range 2..65535.
REQ-002 Parameter SRC_REG, default 5'd2; register-file index whose value is displayed.
REQ-003 clk  input  1  system clock; all state updates on rising edge; one clock only.
REQ-004 nRst  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  enables automatic refresh ticks.
REQ-006 force_refresh  input  1  single-cycle pulse requesting an immediate refresh.
REQ-007 clr_ovr  input  1  clears the overrun flag.
REQ-008 rd_req  output  1  request for the shared register-file read port.
REQ-009 rd_addr  output  5  read address; equals SRC_REG whenever rd_req=1, else 0.
REQ-010 rd_gnt  input  1  grant from the read-port arbiter; rd_data is valid in any cycle with rd_req=1 and rd_gnt=1.
REQ-011 rd_data  input  32  register-file read data (combinational read).
REQ-012 HEX0..HEX7  output  7 each  active-low segments {g,f,e,d,c,b,a}; HEXn shows rd_data[4n+3:4n].
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 overrun  output  1  sticky flag; a refresh trigger arrived while busy.

Function
REQ-015 Tick counter SHALL count 0..REFRESH_DIV-1 and wrap, free-running while en=1; held at 0 while en=0.
REQ-016 tick SHALL be asserted for one cycle when the counter equals REFRESH_DIV-1 and en=1.
REQ-017 trigger = tick OR force_refresh; simultaneous tick and force SHALL count as one trigger.
REQ-018 States: IDLE, REQ, UPDATE.
REQ-019 IDLE: on trigger SHALL go to REQ next cycle; otherwise remain.
REQ-020 REQ: rd_req=1; in the first cycle with rd_gnt=1, SHALL capture rd_data into a 32-bit snapshot, clear digit index to 0, and go to UPDATE; rd_req SHALL be 0 the following cycle.
REQ-021 REQ with no grant SHALL wait indefinitely, with rd_req held high and rd_addr stable.
REQ-022 UPDATE: each cycle SHALL write the decoded snapshot nibble[idx] to HEX[idx] and increment idx; after idx=7 SHALL return to IDLE.
REQ-023 A full refresh SHALL take 1 + (grant wait) + 8 cycles; HEX0 updates in the cycle after the grant, and HEX7 updates 8 cycles after the grant.
REQ-024 HEX outputs not yet written in the current refresh SHALL hold their previous values (no blanking mid-update).
REQ-025 A trigger while busy=1 SHALL be dropped, not queued, and SHALL set overrun.
REQ-026 clr_ovr SHALL clear overrun; if clr_ovr and a new overrun event coincide, set wins.
REQ-027 Deasserting en mid-refresh SHALL let the current refresh complete; no new automatic ticks follow.
REQ-028 Nibble decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Reset
REQ-029 While nRst=0: state IDLE; counter 0; snapshot 0; idx 0; rd_req 0; rd_addr 0; busy 0; overrun 0; all HEXn = 7'b1111111 (blank).
REQ-030 Reset asserted mid-refresh SHALL abort immediately; after release no refresh occurs until the next trigger.

Structure
REQ-031 State enum type, the blank code 7'b1111111, and the register-index width (5) SHALL live in the shared cpu_types_pkg.
REQ-032 The nibble-to-segment decoder SHALL be a separate combinational sub-module, sevenseg_dec.
REQ-033 HEX registers SHALL be the only storage of displayed values; no combinational path from rd_data to HEXn.

Verification (REFRESH_DIV=4, SRC_REG=2)
REQ-034 Reset, en=0, no force for 20 cycles -> all HEX=1111111, rd_req never 1, busy=0.
REQ-035 en=1, rd_gnt tied 1, rd_data=32'h76543210 -> rd_req at cycle 4 with rd_addr=2; HEX0..HEX7 show 0..7 over the next 8 cycles; busy falls after HEX7.
REQ-036 force_refresh pulse with rd_gnt held 0 for 5 cycles, then 1, rd_data=32'hFEDCBA98 -> rd_req high 6 cycles; HEX0=0000000 (8), HEX7=0001110 (F).
REQ-037 force_refresh pulse during UPDATE -> overrun=1, no extra rd_req; clr_ovr pulse -> overrun=0.
REQ-038 nRst low at idx=3 with rd_data=32'h0 -> all HEX=1111111 immediately, rd_req=0, state IDLE.
REQ-039 tick and force_refresh in the same cycle -> exactly one refresh, overrun stays 0.
